commit_ring_mc: RTL and testbench
=================================

Name: commit_ring_mc

Overview:
- Parametrised successor to the in-order commit ring: tracks issued instructions in program order and releases them one per cycle to the owning commit channel.
- Generalised in depth and channel count (GPR/FPR/B become channel indices 0..N_CH-1).
- Adds full-depth usage, a registered occupancy count, an overflow-safe in_count, and a synchronous flush.
- Sits between the issue stage and the per-register-file commit units.

Parameters:
DEPTH_LOG2, 4, log2 of ring depth; DEPTH = 2**DEPTH_LOG2, all DEPTH entries usable
N_CH, 3, number of commit channels (0=GPR, 1=FPR, 2=B by convention); must be >= 2
CH_W, $clog2(N_CH), width of channel index

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all entries (pipeline squash)
issue_valid  in  1  issue request
issue_ready  out  1  ring can accept an entry
issue_ch  in  CH_W  commit channel of issued entry; values >= N_CH illegal
issue_in  in  1  entry is an input-port instruction (counted in in_count)
commit_valid  out  N_CH  one-hot; bit c set when head entry belongs to channel c
commit_ready  in  N_CH  per-channel commit acceptance
commit_in  out  1  in flag of head entry; 0 when empty
empty  out  1  count==0
full  out  1  count==DEPTH
count  out  DEPTH_LOG2+1  occupied entries, 0..DEPTH
in_count  out  DEPTH_LOG2+1  occupied entries with in flag set, 0..DEPTH

Behaviour:
- State: per-entry {ch, in}; issue_ptr and commit_ptr (DEPTH_LOG2 bits, natural wrap DEPTH-1 -> 0); count and in_count registers.
- reset_n low (async): pointers = 0, count = 0, in_count = 0, entries cleared. Outputs: issue_ready=1, empty=1, full=0, commit_valid=0, commit_in=0.
- issue_ready = !full && !flush. It is not combinationally dependent on commit_ready, so there is no bypass when full.
- issue = issue_valid && issue_ready. On issue: entry[issue_ptr] <= {issue_ch, issue_in}; issue_ptr++.
- commit_valid = empty ? 0 : (1 << entry[commit_ptr].ch). Combinational from registers only.
- commit = |(commit_valid & commit_ready). On commit: commit_ptr++. At most one commit per cycle.
- count next value: +1 on issue only, -1 on commit only, unchanged if both or neither.
- in_count next value: +issue_in on issue, -commit_in on commit, both applied in the same cycle.
- Latency: an issued entry is visible at the head one cycle later, when issued into an empty ring.
- Simultaneous issue+commit when full: issue blocked (issue_ready=0); commit proceeds; next cycle count = DEPTH-1.
- Simultaneous issue+commit, non-full and non-empty: both pointers advance, count unchanged.
- Empty: commit_valid = 0, so commit_ready is ignored.
- flush: next cycle pointers = 0, count = 0, in_count = 0. flush overrides issue and commit in the same cycle; commit_valid still reflects the current head that cycle, but no pointer advances.
- Reset mid-operation: immediate async clear regardless of flush or handshakes.
- Illegal issue_ch >= N_CH: the entry commits on no channel. A simulation assertion fires; behaviour is otherwise undefined.

Optional Feature:
Macro COMMIT_RING_MC_STATS_EN.
- Defined: adds two outputs, both reset to 0 by reset_n and cleared by flush.
  - stall_cycles (32-bit, saturating at 2**32-1): increments each cycle issue_valid && !issue_ready.
  - max_count (DEPTH_LOG2+1 bits): high-water mark of count.
- Not defined: these ports and registers do not exist. Core behaviour is identical.

Test Plan:
- DEPTH_LOG2=4, N_CH=3, after reset: issue 16 entries (ch=0, in=0) with commit_ready=0 -> full=1, count=16, issue_ready=0, commit_valid=3'b001; a 17th issue_valid is not accepted.
- Fill with alternating ch 0/1/2, commit_ready=3'b111 -> commit_valid sequence 001,010,100,... one commit per cycle; entry 16 drains, then empty=1.
- commit_ready=3'b010 with head ch=0 -> no commit, pointers hold, count unchanged (head-of-line blocking).
- Steady state with count=5: issue+commit every cycle for 40 cycles (pointer wrap ×2) -> count stays 5; commit order matches issue order.
- Issue 16 entries all in=1 -> in_count=16, no overflow to 0; commit 3 -> in_count=13; mixed issue in=1 and commit in=0 in the same cycle -> in_count +1.
- flush at count=9 with issue_valid=1 and commit_ready=all in the same cycle -> next cycle count=0, in_count=0, empty=1, nothing committed. reset_n pulse mid-fill -> outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/commit_ring_mc.sv
// In-order commit ring: records issued entries {channel, in flag} in program order and
// releases the head to its channel, one per cycle. Optional stats via COMMIT_RING_MC_STATS_EN.
module commit_ring_mc #(
   parameter int DEPTH_LOG2 = 4,
   parameter int N_CH       = 3,
   parameter int CH_W       = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  issue_valid,
   output logic                  issue_ready,
   input  logic [CH_W-1:0]       issue_ch,
   input  logic                  issue_in,
   output logic [N_CH-1:0]       commit_valid,
   input  logic [N_CH-1:0]       commit_ready,
   output logic                  commit_in,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic [DEPTH_LOG2:0]   in_count
`ifdef COMMIT_RING_MC_STATS_EN
   ,
   output logic [31:0]           stall_cycles,
   output logic [DEPTH_LOG2:0]   max_count
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CNT_W = DEPTH_LOG2 + 1;
   localparam logic [CH_W:0] N_CH_L = N_CH[CH_W:0];

   logic [DEPTH-1:0][CH_W-1:0] ent_ch_q, ent_ch_d;
   logic [DEPTH-1:0]           ent_in_q, ent_in_d;
   logic [DEPTH_LOG2-1:0]      issue_ptr_q, issue_ptr_d, commit_ptr_q, commit_ptr_d;
   logic [CNT_W-1:0]           count_q, count_d, in_count_q, in_count_d;
   logic [CH_W-1:0]            head_ch;
   logic                       do_issue, do_commit;

   // Head-side outputs depend on registered state only.
   always_comb begin
      empty       = (count_q == '0);
      full        = (count_q == CNT_W'(DEPTH));
      issue_ready = !full && !flush;
      do_issue    = issue_valid && issue_ready;
      head_ch     = ent_ch_q[commit_ptr_q];
      commit_in   = !empty && ent_in_q[commit_ptr_q];
      for (int c = 0; c < N_CH; c++)
         commit_valid[c] = !empty && (head_ch == CH_W'(c));
      do_commit   = (|(commit_valid & commit_ready)) && !flush;
      count       = count_q;
      in_count    = in_count_q;
   end

   always_comb begin
      ent_ch_d     = ent_ch_q;
      ent_in_d     = ent_in_q;
      issue_ptr_d  = issue_ptr_q;
      commit_ptr_d = commit_ptr_q;
      count_d      = count_q;
      in_count_d   = in_count_q;
      if (flush) begin
         issue_ptr_d  = '0;
         commit_ptr_d = '0;
         count_d      = '0;
         in_count_d   = '0;
      end else begin
         if (do_issue) begin
            ent_ch_d[issue_ptr_q] = issue_ch;
            ent_in_d[issue_ptr_q] = issue_in;
            issue_ptr_d           = issue_ptr_q + 1'b1;
         end
         if (do_commit)
            commit_ptr_d = commit_ptr_q + 1'b1;
         if (do_issue && !do_commit)
            count_d = count_q + 1'b1;
         else if (!do_issue && do_commit)
            count_d = count_q - 1'b1;
         // Both adjustments land together so a full ring of in-entries stays at DEPTH.
         in_count_d = in_count_q + CNT_W'(do_issue && issue_in) - CNT_W'(do_commit && commit_in);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ent_ch_q     <= '0;
         ent_in_q     <= '0;
         issue_ptr_q  <= '0;
         commit_ptr_q <= '0;
         count_q      <= '0;
         in_count_q   <= '0;
      end else begin
         ent_ch_q     <= ent_ch_d;
         ent_in_q     <= ent_in_d;
         issue_ptr_q  <= issue_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         count_q      <= count_d;
         in_count_q   <= in_count_d;
      end
   end

`ifdef COMMIT_RING_MC_STATS_EN
   logic [31:0]      stall_q, stall_d;
   logic [CNT_W-1:0] max_q, max_d;

   always_comb begin
      stall_d = stall_q;
      max_d   = max_q;
      if (flush) begin
         stall_d = '0;
         max_d   = '0;
      end else begin
         if (issue_valid && !issue_ready && stall_q != '1)
            stall_d = stall_q + 1'b1;
         if (count_d > max_q)
            max_d = count_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_q <= '0;
         max_q   <= '0;
      end else begin
         stall_q <= stall_d;
         max_q   <= max_d;
      end
   end

   assign stall_cycles = stall_q;
   assign max_count    = max_q;
`endif

   a_legal_ch : assert property (@(posedge clk) disable iff (!reset_n)
      do_issue |-> ({1'b0, issue_ch} < N_CH_L));

endmodule

// File: tb/tb_commit_ring_mc.sv
// Directed bench for commit_ring_mc (DEPTH_LOG2=4, N_CH=3): fill/full, ordered drain,
// head-of-line blocking, steady-state wrap, in_count, flush and async reset.
module tb_commit_ring_mc;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       flush;
   logic       issue_valid;
   logic       issue_ready;
   logic [1:0] issue_ch;
   logic       issue_in;
   logic [2:0] commit_valid;
   logic [2:0] commit_ready;
   logic       commit_in;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic [4:0] in_count;
`ifdef COMMIT_RING_MC_STATS_EN
   logic [31:0] stall_cycles;
   logic [4:0]  max_count;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   commit_ring_mc #(.DEPTH_LOG2(4), .N_CH(3)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_ch(issue_ch), .issue_in(issue_in),
      .commit_valid(commit_valid), .commit_ready(commit_ready),
      .commit_in(commit_in), .empty(empty), .full(full),
      .count(count), .in_count(in_count)
`ifdef COMMIT_RING_MC_STATS_EN
      , .stall_cycles(stall_cycles), .max_count(max_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] ch, input logic inf,
                        input logic [2:0] rdy, input logic fl);
      issue_valid  = v;
      issue_ch     = ch;
      issue_in     = inf;
      commit_ready = rdy;
      flush        = fl;
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 3'b000, 0);
      reset_n = 1'b0;
      repeat (2) tick();
      n_chk++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
      n_chk++; if (full !== 1'b0)      begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
      n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
      n_chk++; if (commit_valid !== 3'b000) begin n_fail++; $display("FAIL reset_cvalid got=%b exp=000", commit_valid); end
      n_chk++; if (count !== 5'd0 || in_count !== 5'd0 || commit_in !== 1'b0)
         begin n_fail++; $display("FAIL reset_counts got=%0d/%0d/%b exp=0/0/0", count, in_count, commit_in); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_fill_full();
      drive(1, 0, 0, 3'b000, 0);
      repeat (16) tick();
      n_chk++; if (full !== 1'b1)      begin n_fail++; $display("FAIL fill_full got=%b exp=1", full); end
      n_chk++; if (count !== 5'd16)    begin n_fail++; $display("FAIL fill_count got=%0d exp=16", count); end
      n_chk++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready got=%b exp=0", issue_ready); end
      n_chk++; if (commit_valid !== 3'b001) begin n_fail++; $display("FAIL fill_cvalid got=%b exp=001", commit_valid); end
      tick();
      n_chk++; if (count !== 5'd16)    begin n_fail++; $display("FAIL fill_17th got=%0d exp=16", count); end
      // Issue held high while full: commit drains one, issue blocked that cycle.
      drive(1, 0, 0, 3'b001, 0);
      tick();
      n_chk++; if (count !== 5'd15)    begin n_fail++; $display("FAIL full_commit got=%0d exp=15", count); end
      drive(0, 0, 0, 3'b001, 0);
      repeat (15) tick();
      n_chk++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL fill_drain_empty got=%b exp=1", empty); end
   endtask

   task automatic test_order();
      logic [2:0] e;
      drive(0, 0, 0, 3'b000, 0);
      for (int i = 0; i < 16; i++) begin
         drive(1, 2'(i % 3), i[0], 3'b000, 0);
         tick();
      end
      drive(0, 0, 0, 3'b111, 0);
      for (int i = 0; i < 16; i++) begin
         e = 3'b001 << (i % 3);
         n_chk++; if (commit_valid !== e || commit_in !== i[0])
            begin n_fail++; $display("FAIL order_%0d got=%b/%b exp=%b/%b", i, commit_valid, commit_in, e, i[0]); end
         tick();
      end
      n_chk++; if (empty !== 1'b1 || commit_valid !== 3'b000)
         begin n_fail++; $display("FAIL order_empty got=%b/%b exp=1/000", empty, commit_valid); end
   endtask

   task automatic test_hol_block();
      drive(1, 0, 0, 3'b000, 0);
      tick();
      drive(1, 1, 0, 3'b010, 0);
      tick();
      drive(0, 0, 0, 3'b010, 0);
      tick();
      n_chk++; if (count !== 5'd2 || commit_valid !== 3'b001)
         begin n_fail++; $display("FAIL hol_block got=%0d/%b exp=2/001", count, commit_valid); end
      drive(0, 0, 0, 3'b001, 0);
      tick();
      n_chk++; if (count !== 5'd1 || commit_valid !== 3'b010)
         begin n_fail++; $display("FAIL hol_release got=%0d/%b exp=1/010", count, commit_valid); end
      drive(0, 0, 0, 3'b010, 0);
      tick();
   endtask

   task automatic test_back_to_back();
      logic [1:0] q[$];
      logic [2:0] e;
      for (int i = 0; i < 5; i++) begin
         drive(1, 2'(i % 3), 0, 3'b000, 0);
         q.push_back(2'(i % 3));
         tick();
      end
      for (int i = 0; i < 40; i++) begin
         drive(1, 2'((5 + i) % 3), 0, 3'b111, 0);
         e = 3'b001 << q[0];
         n_chk++; if (commit_valid !== e)
            begin n_fail++; $display("FAIL b2b_head_%0d got=%b exp=%b", i, commit_valid, e); end
         void'(q.pop_front());
         q.push_back(2'((5 + i) % 3));
         tick();
         n_chk++; if (count !== 5'd5)
            begin n_fail++; $display("FAIL b2b_count_%0d got=%0d exp=5", i, count); end
      end
      drive(0, 0, 0, 3'b111, 0);
      repeat (5) tick();
      n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_drain got=%b exp=1", empty); end
   endtask

   task automatic test_in_count();
      drive(1, 1, 1, 3'b000, 0);
      repeat (16) tick();
      n_chk++; if (in_count !== 5'd16) begin n_fail++; $display("FAIL inc_full got=%0d exp=16", in_count); end
      drive(0, 0, 0, 3'b010, 0);
      repeat (3) tick();
      n_chk++; if (in_count !== 5'd13) begin n_fail++; $display("FAIL inc_commit3 got=%0d exp=13", in_count); end
      repeat (13) tick();
      drive(1, 0, 0, 3'b000, 0);
      tick();
      drive(1, 1, 1, 3'b001, 0);
      tick();
      n_chk++; if (in_count !== 5'd1 || count !== 5'd1)
         begin n_fail++; $display("FAIL inc_mixed got=%0d/%0d exp=1/1", in_count, count); end
      drive(0, 0, 0, 3'b010, 0);
      tick();
      n_chk++; if (in_count !== 5'd0 || empty !== 1'b1)
         begin n_fail++; $display("FAIL inc_drain got=%0d/%b exp=0/1", in_count, empty); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 9; i++) begin
         drive(1, 2'(i % 3), (i < 4), 3'b000, 0);
         tick();
      end
      n_chk++; if (count !== 5'd9 || in_count !== 5'd4)
         begin n_fail++; $display("FAIL flush_pre got=%0d/%0d exp=9/4", count, in_count); end
      drive(1, 1, 1, 3'b111, 1);
      #1;
      n_chk++; if (issue_ready !== 1'b0 || commit_valid !== 3'b001)
         begin n_fail++; $display("FAIL flush_cycle got=%b/%b exp=0/001", issue_ready, commit_valid); end
      tick();
      drive(0, 0, 0, 3'b000, 0);
      n_chk++; if (count !== 5'd0 || in_count !== 5'd0 || empty !== 1'b1 || commit_valid !== 3'b000)
         begin n_fail++; $display("FAIL flush_post got=%0d/%0d/%b/%b exp=0/0/1/000", count, in_count, empty, commit_valid); end
      drive(1, 2, 1, 3'b000, 0);
      tick();
      drive(0, 0, 0, 3'b000, 0);
      n_chk++; if (commit_valid !== 3'b100 || commit_in !== 1'b1 || count !== 5'd1)
         begin n_fail++; $display("FAIL flush_reissue got=%b/%b/%0d exp=100/1/1", commit_valid, commit_in, count); end
      drive(0, 0, 0, 3'b100, 0);
      tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 1, 3'b000, 0);
         tick();
      end
      #2 reset_n = 1'b0;
      #1;
      n_chk++; if (count !== 5'd0 || in_count !== 5'd0 || empty !== 1'b1 || full !== 1'b0)
         begin n_fail++; $display("FAIL rstmid_state got=%0d/%0d/%b/%b exp=0/0/1/0", count, in_count, empty, full); end
      n_chk++; if (commit_valid !== 3'b000 || commit_in !== 1'b0 || issue_ready !== 1'b1)
         begin n_fail++; $display("FAIL rstmid_out got=%b/%b/%b exp=000/0/1", commit_valid, commit_in, issue_ready); end
      drive(0, 0, 0, 3'b000, 0);
      tick();
      reset_n = 1'b1;
      tick();
      n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_release got=%b exp=1", empty); end
   endtask

   initial begin
      test_reset();
      test_fill_full();
      test_order();
      test_hol_block();
      test_back_to_back();
      test_in_count();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
